// File: rtl/arrow_judge.sv
// Arrow judge: queues beat arrows in a small FIFO and scores button
// presses against the oldest pending arrow (hit/miss, score, combo).
module arrow_judge #(
  parameter int NUM_ARROWS = 4,
  parameter int ARROW_BASE = 10,
  parameter int CODE_W     = 4,
  parameter int DEPTH      = 4,
  parameter int WINDOW     = 8,
  parameter int SCORE_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       play,
  input  logic                       beat_tick,
  input  logic [CODE_W-1:0]          arrow_in,
  input  logic [NUM_ARROWS-1:0]      btn,
  output logic                       hit,
  output logic                       miss,
  output logic [SCORE_W-1:0]         score,
  output logic [SCORE_W-1:0]         combo,
  output logic                       head_valid,
  output logic [CODE_W-1:0]          head_code,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       code_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [CODE_W-1:0] BASE = CODE_W'(ARROW_BASE);
  localparam logic [GW-1:0]     LAST = GW'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ARMED
  } state_t;

  state_t state, state_nxt;

  logic [CODE_W-1:0]     mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [GW-1:0]         age;
  logic [NUM_ARROWS-1:0] btn_q, rise, head_hot;
  logic [CODE_W-1:0]     in_idx, head_idx;
  logic                  in_ok, armed, start, full;
  logic                  beat_ok, do_hit, do_jmiss, do_pop;
  logic                  do_push, do_drop, bad_code;

  always_comb begin
    rise     = btn & ~btn_q;
    in_idx   = arrow_in - BASE;
    in_ok    = {1'b0, in_idx} < (CODE_W + 1)'(NUM_ARROWS);
    head_idx = mem[rd_ptr] - BASE;
    head_hot = NUM_ARROWS'(1) << head_idx;
    armed    = play && (state == S_ARMED);
    start    = play && (state == S_IDLE);
    full     = (cnt == CW'(DEPTH));
  end

  // A press is judged even at the last window cycle, so a hit beats timeout
  always_comb begin
    do_hit   = armed && (rise != '0) && (rise == head_hot);
    do_jmiss = armed && (((rise != '0) && (rise != head_hot)) ||
                         ((rise == '0) && (age == LAST)));
    do_pop   = do_hit || do_jmiss;
    beat_ok  = beat_tick && play && (state != S_IDLE);
    do_push  = beat_ok && in_ok && (!full || do_pop);
    do_drop  = beat_ok && in_ok && full && !do_pop;
    bad_code = beat_ok && !in_ok;
    cnt_nxt  = cnt + CW'(do_push) - CW'(do_pop);
  end

  always_comb begin
    state_nxt = state;
    if (!play) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_WAIT;
        S_WAIT:  if (do_push) state_nxt = S_ARMED;
        S_ARMED: if (cnt_nxt == '0) state_nxt = S_WAIT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (play && do_push) mem[wr_ptr] <= arrow_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      age    <= '0;
    end else if (!play) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      age    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
      // age restarts whenever a different entry becomes the head
      if ((do_pop && cnt_nxt != '0) || (do_push && cnt == '0))
        age <= '0;
      else if (armed)
        age <= age + GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q    <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      score    <= '0;
      combo    <= '0;
      code_err <= 1'b0;
    end else begin
      btn_q <= btn;
      hit   <= do_hit;
      miss  <= do_jmiss || do_drop;
      if (start) begin
        score    <= '0;
        combo    <= '0;
        code_err <= 1'b0;
      end else begin
        if (do_hit && score != '1) score <= score + SCORE_W'(1);
        if (do_jmiss || do_drop)
          combo <= '0;
        else if (do_hit && combo != '1)
          combo <= combo + SCORE_W'(1);
        if (bad_code) code_err <= 1'b1;
      end
    end
  end

  always_comb begin
    head_valid = (cnt != '0);
    head_code  = head_valid ? mem[rd_ptr] : '0;
    count      = cnt;
  end

endmodule

// File: tb/tb_arrow_judge.sv
// Bench for arrow_judge: directed stimulus with a queue of expected
// hit/miss events checked by an independent monitor.
module tb_arrow_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play = 1'b0;
  logic       beat_tick = 1'b0;
  logic [3:0] arrow_in = '0;
  logic [3:0] btn = '0;
  logic       hit, miss, head_valid, code_err;
  logic [7:0] score, combo;
  logic [3:0] head_code;
  logic [2:0] count;

  arrow_judge dut (
    .clk(clk), .rst(rst), .play(play), .beat_tick(beat_tick),
    .arrow_in(arrow_in), .btn(btn), .hit(hit), .miss(miss),
    .score(score), .combo(combo), .head_valid(head_valid),
    .head_code(head_code), .count(count), .code_err(code_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit h;
    int sc;
    int co;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_score = 0;
  int   exp_combo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, expv, cyc);
    end
  endtask

  task automatic expect_evt(int c, bit h);
    exp_t e;
    if (h) begin
      if (exp_score < 255) exp_score++;
      if (exp_combo < 255) exp_combo++;
    end else begin
      exp_combo = 0;
    end
    e.cyc = c;
    e.h   = h;
    e.sc  = exp_score;
    e.co  = exp_combo;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: expected at cycle %0d",
                 q[0].cyc);
        void'(q.pop_front());
      end
      if (hit || miss) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: hit=%0b miss=%0b at cycle %0d",
                   hit, miss, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("evt_cycle", cyc, e.cyc);
          chk("evt_hit", int'(hit), int'(e.h));
          chk("evt_miss", int'(miss), int'(!e.h));
          chk("evt_score", int'(score), e.sc);
          chk("evt_combo", int'(combo), e.co);
        end
      end
    end
  end

  task automatic beat(logic [3:0] code);
    beat_tick = 1'b1;
    arrow_in  = code;
    @(negedge clk);
    beat_tick = 1'b0;
  endtask

  task automatic press(logic [3:0] b, bit h);
    btn = b;
    expect_evt(cyc + 1, h);
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_hv", int'(head_valid), 0);
    chk("rst_count", int'(count), 0);
    rst = 1'b0;
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);

    // basic push and hit
    beat(4'd12);
    chk("push_hv", int'(head_valid), 1);
    chk("push_code", int'(head_code), 12);
    chk("push_count", int'(count), 1);
    press(4'b0100, 1'b1);
    chk("hit_count", int'(count), 0);

    // timeout: miss exactly WINDOW cycles after becoming head
    expect_evt(cyc + 9, 1'b0);
    beat(4'd10);
    repeat (10) @(negedge clk);
    chk("tmo_count", int'(count), 0);
    chk("tmo_hv", int'(head_valid), 0);

    // wrong presses
    beat(4'd11);
    press(4'b0011, 1'b0);
    beat(4'd11);
    press(4'b0001, 1'b0);
    chk("wrong_count", int'(count), 0);

    // overflow drop, then full with simultaneous pop
    beat(4'd10);
    beat(4'd11);
    beat(4'd12);
    beat(4'd13);
    chk("fill_count", int'(count), 4);
    expect_evt(cyc + 1, 1'b0);
    beat(4'd13);
    chk("drop_count", int'(count), 4);
    chk("drop_head", int'(head_code), 10);
    beat_tick = 1'b1;
    arrow_in  = 4'd13;
    btn       = 4'b0001;
    expect_evt(cyc + 1, 1'b1);
    @(negedge clk);
    beat_tick = 1'b0;
    btn       = '0;
    chk("swap_count", int'(count), 4);
    chk("swap_head", int'(head_code), 11);
    @(negedge clk);
    press(4'b0010, 1'b1);
    press(4'b0100, 1'b1);
    press(4'b1000, 1'b1);
    press(4'b1000, 1'b1);
    chk("drain_count", int'(count), 0);

    // a press on the last window cycle still hits
    beat(4'd11);
    repeat (7) @(negedge clk);
    press(4'b0010, 1'b1);
    chk("edge_score", int'(score), 7);

    // bad code and ignored press while waiting
    beat(4'd3);
    chk("bad_err", int'(code_err), 1);
    chk("bad_count", int'(count), 0);
    btn = 4'b0001;
    @(negedge clk);
    btn = '0;
    @(negedge clk);

    // restarting the game clears score, combo and code_err
    play = 1'b0;
    @(negedge clk);
    chk("idle_err_hold", int'(code_err), 1);
    play = 1'b1;
    @(negedge clk);
    exp_score = 0;
    exp_combo = 0;
    chk("clr_err", int'(code_err), 0);
    chk("clr_score", int'(score), 0);
    chk("clr_combo", int'(combo), 0);

    // saturation
    for (int i = 0; i < 300; i++) begin
      beat(4'd10);
      press(4'b0001, 1'b1);
    end
    chk("sat_score", int'(score), 255);
    chk("sat_combo", int'(combo), 255);

    // asynchronous reset mid-window
    beat(4'd12);
    #2 rst = 1'b1;
    #1;
    chk("arst_hit", int'(hit), 0);
    chk("arst_miss", int'(miss), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_combo", int'(combo), 0);
    chk("arst_hv", int'(head_valid), 0);
    chk("arst_code", int'(head_code), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_err", int'(code_err), 0);
    play = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
